// File: rtl/fast_pulse_accumulator.sv
// fast_pulse_accumulator
//
// Counts single-cycle event pulses arriving from the slow-to-fast
// synchronizer and hands them downstream in batches. A batch is closed and
// reported either when its running count reaches THRESH, or when TIMEOUT
// cycles have passed since its first pulse. Reports use a valid/ready
// handshake. Pulses that arrive while a report is stalled keep accumulating
// into the next batch, so none are lost unless the counter saturates.
//
// Optional feature macro: FAST_PULSE_ACC_OVF_FLAG_EN
//   When defined, a sticky overflow output flags pulses dropped because the
//   accumulator was already at its maximum value. It is cleared only by rst.
//
// Ports:
//   clk_fast   in   fast clock, rising edge
//   rst        in   synchronous active-high reset
//   pulse_in   in   single-cycle event pulse
//   evt_valid  out  report available
//   evt_ready  in   consumer accepts the report
//   evt_count  out  number of events in the report (CNT_W bits)
//   busy       out  state is not IDLE
//   overflow   out  sticky saturation flag (only with the macro defined)

module fast_pulse_accumulator #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned THRESH  = 16,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TMR_W   = 16
) (
    input  logic             clk_fast,
    input  logic             rst,
    input  logic             pulse_in,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_count,
    output logic             busy
`ifdef FAST_PULSE_ACC_OVF_FLAG_EN
    ,
    output logic             overflow
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        REPORT
    } state_t;

    localparam logic [CNT_W-1:0] ACC_MAX  = '1;
    localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);
    localparam logic [TMR_W-1:0] TMO_V    = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    state_t           state;
    logic [CNT_W-1:0] acc;
    logic [TMR_W-1:0] timer;

    logic [CNT_W-1:0] acc_next;
    logic             thresh_hit;
    logic             timer_done;
    logic             acc_full;

    // Saturating increment: a pulse on a full accumulator is dropped.
    always_comb begin
        acc_full   = (acc == ACC_MAX);
        acc_next   = (pulse_in && !acc_full) ? acc + CNT_W'(1) : acc;
        thresh_hit = (acc_next >= THRESH_V);
        timer_done = (timer == TMO_V);
    end

    always_ff @(posedge clk_fast) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            timer     <= '0;
            evt_valid <= 1'b0;
            evt_count <= '0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pulse_in) begin
                        busy <= 1'b1;
                        if (thresh_hit) begin
                            evt_count <= acc_next;
                            evt_valid <= 1'b1;
                            acc       <= '0;
                            state     <= REPORT;
                        end else begin
                            acc   <= acc_next;
                            timer <= TMR_ONE;
                            state <= ACCUM;
                        end
                    end
                end

                ACCUM: begin
                    // Threshold and timeout both report acc_next, so the
                    // shared branch gives threshold its priority for free.
                    if (thresh_hit || timer_done) begin
                        evt_count <= acc_next;
                        evt_valid <= 1'b1;
                        acc       <= '0;
                        state     <= REPORT;
                    end else begin
                        acc   <= acc_next;
                        timer <= timer + TMR_ONE;
                    end
                end

                REPORT: begin
                    if (evt_ready) begin
                        if (thresh_hit) begin
                            // Back-to-back report: evt_valid stays high.
                            evt_count <= acc_next;
                            acc       <= '0;
                        end else if (acc_next != '0) begin
                            evt_valid <= 1'b0;
                            acc       <= acc_next;
                            timer     <= TMR_ONE;
                            state     <= ACCUM;
                        end else begin
                            evt_valid <= 1'b0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end else begin
                        // Stalled: evt_count holds, pulses keep counting.
                        acc <= acc_next;
                    end
                end

                default: begin
                    state     <= IDLE;
                    acc       <= '0;
                    evt_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef FAST_PULSE_ACC_OVF_FLAG_EN
    always_ff @(posedge clk_fast) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (pulse_in && acc_full) begin
            overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/fast_pulse_accumulator.md
# fast_pulse_accumulator

Fast-domain consumer of single-cycle event pulses produced by the slow-to-fast single-bit synchronizer. It counts incoming pulses and batches them into count reports. A report is issued when the running count reaches a threshold, or when a timeout expires after the first event of a batch. Reports go to a downstream consumer over a valid/ready handshake, and no pulse is lost while the consumer stalls, apart from counter saturation.

## Interface
- CNT_W, 8, width of the event counter and of evt_count.
- THRESH, 16, count that triggers an immediate report; legal range 1..2^CNT_W-1.
- TIMEOUT, 64, cycles from the first pulse of a batch to a forced report; must be at least 1.
- TMR_W, 16, timer width; must satisfy 2^TMR_W > TIMEOUT.

Ports:
- clk_fast  input  1  fast clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- pulse_in  input  1  single-cycle event pulse from the synchronizer; sampled every edge.
- evt_valid  output  1  a report is available.
- evt_ready  input  1  the consumer accepts the report.
- evt_count  output  CNT_W  number of events in the report.
- busy  output  1  high when the state is not IDLE.
- overflow  output  1  sticky saturation flag; present only when the macro is defined.

## Operation
- Definitions:
  - acc_next = min(acc + pulse_in, 2^CNT_W-1).
  - "Report" means: evt_count <= acc_next; evt_valid <= 1; acc <= 0; state <= REPORT.
- IDLE (acc=0):
  - pulse_in=1 and acc_next>=THRESH (only possible when THRESH=1): report.
  - pulse_in=1 otherwise: acc<=1, timer<=1, go to ACCUM.
- ACCUM:
  - acc<=acc_next on every edge.
  - acc_next>=THRESH, or timer==TIMEOUT: report. Threshold has priority, and the reported count is the same in either case.
  - Otherwise timer<=timer+1.
- REPORT:
  - evt_valid=1. evt_count is held stable while evt_ready=0.
  - acc keeps accumulating pulses; the timer is idle.
  - On an edge with evt_ready=1:
    - acc_next>=THRESH: report again, back to back, and stay in REPORT.
    - acc_next!=0: evt_valid<=0, timer<=1, go to ACCUM.
    - Otherwise: evt_valid<=0, go to IDLE.
- A pulse sampled on the same edge that issues a report is included in that report.
- Saturation: acc stops at 2^CNT_W-1. Further pulses are dropped silently, or flagged when the macro is defined.
- Reset while rst=1 at an edge:
  - state=IDLE, acc=0, timer=0, evt_valid=0, evt_count=0, overflow=0.
  - A pulse_in sampled on a reset edge is discarded.
  - Reset in ACCUM or REPORT abandons the batch with no report.

## Timing
- Output reset values: evt_valid=0, evt_count=0, busy=0, overflow=0.
- Threshold latency: evt_valid rises on the edge that samples the THRESH-th pulse and is visible in the following cycle.
- Timeout latency: if the first pulse is sampled at edge E0 and fewer than THRESH pulses follow, evt_valid rises at edge E(TIMEOUT).
- Back-to-back reports: with evt_ready held at 1 and pulses arriving continuously, evt_valid can remain high across consecutive reports.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Behaviour is undefined if evt_ready is asserted while evt_valid=0; the bench must never drive this.

## Configuration
- Macro: FAST_PULSE_ACC_OVF_FLAG_EN.
- Defined:
  - The overflow port exists.
  - It is set on any edge where pulse_in=1 and acc==2^CNT_W-1.
  - Once set, it is cleared only by rst.
- Undefined:
  - No overflow port and no flag register.
  - Saturation is silent.

## Test plan
- Threshold report (CNT_W=8, THRESH=4, TIMEOUT=10, evt_ready=1):
  - Stimulus: 4 pulses on consecutive cycles.
  - Response: evt_valid for 1 cycle, evt_count=4, then busy=0.
- Timeout report (same parameters):
  - Stimulus: a single pulse at E0.
  - Response: evt_valid rises at E10 with evt_count=1.
- Stall with back-to-back report (same parameters):
  - Stimulus: evt_ready=0 and a pulse every cycle for 20 cycles, then evt_ready=1 with pulses stopped.
  - Response: first report is evt_count=4, held stable throughout the stall. The next report follows immediately, with evt_count equal to the number of pulses sampled after the first report edge; the bench computes this value and checks it.
- Saturation (CNT_W=3, THRESH=7, macro defined):
  - Stimulus: evt_ready=0 and 20 pulses.
  - Response: second report evt_count=7, overflow=1, and overflow stays 1 until rst.
- Reset mid-batch (THRESH=4):
  - Stimulus: 2 pulses, then rst=1 for one cycle.
  - Response: no evt_valid, busy=0. A subsequent single pulse times out with evt_count=1.
- Boundary (THRESH=1):
  - Stimulus: a single pulse from IDLE.
  - Response: evt_valid rises on that same edge with evt_count=1; ACCUM is never entered.
